// File: rtl/source_handshake_ctrl_if.sv
// Bundles the producer-side valid/ready bus and the request/ack/data link towards the destination domain.
// The source controller takes the master view; the producer/destination environment takes the slave view.
interface source_handshake_ctrl_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
);
   logic                   s_valid;
   logic [DATA_WIDTH-1:0]  s_data;
   logic                   s_ready;
   logic                   ack;
   logic                   request;
   logic [DATA_WIDTH-1:0]  d_out;
   logic                   done;
   logic                   timeout_err;
   logic [COUNT_WIDTH-1:0] xfer_count;

   modport master (
      input  s_valid, s_data, ack,
      output s_ready, request, d_out, done, timeout_err, xfer_count
   );

   modport slave (
      output s_valid, s_data, ack,
      input  s_ready, request, d_out, done, timeout_err, xfer_count
   );
endinterface

// File: rtl/source_handshake_ctrl.sv
// Source half of a four-phase req/ack CDC handshake; request rises 2 edges after accept, falls SYNC_STAGES+1 edges after ack.
// s_ready is low (producer stalls) whenever a word is in flight or the synchronized ack is still high.
module source_handshake_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                   i_clk_s,
   input  logic                   i_rst,
   source_handshake_ctrl_if.master io_hs
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_REQ     = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_ack_sync;
   logic                   w_ack_sync;
   logic                   r_req;
   logic                   w_req_nxt;
   logic [DATA_WIDTH-1:0]  r_dout;
   logic [DATA_WIDTH-1:0]  w_dout_nxt;
   logic                   r_done;
   logic                   w_done_nxt;
   logic                   r_terr;
   logic                   w_terr_nxt;
   logic                   r_acked;
   logic                   w_acked_nxt;
   logic [TW-1:0]          r_tmr;
   logic [TW-1:0]          w_tmr_nxt;
   logic [COUNT_WIDTH-1:0] r_xfer_cnt;
   logic [COUNT_WIDTH-1:0] w_xfer_cnt_nxt;
   logic                   w_s_ready;

   // Only the last synchronizer stage is ever looked at; raw ack never reaches the FSM.
   assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];
   assign w_s_ready  = (r_state == S_IDLE) && !w_ack_sync;

   always_ff @(posedge i_clk_s or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_ack_sync <= '0;
         r_req      <= 1'b0;
         r_dout     <= '0;
         r_done     <= 1'b0;
         r_terr     <= 1'b0;
         r_acked    <= 1'b0;
         r_tmr      <= '0;
         r_xfer_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], io_hs.ack};
         r_req      <= w_req_nxt;
         r_dout     <= w_dout_nxt;
         r_done     <= w_done_nxt;
         r_terr     <= w_terr_nxt;
         r_acked    <= w_acked_nxt;
         r_tmr      <= w_tmr_nxt;
         r_xfer_cnt <= w_xfer_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_req_nxt      = r_req;
      w_dout_nxt     = r_dout;
      w_done_nxt     = 1'b0;
      w_terr_nxt     = r_terr;
      w_acked_nxt    = r_acked;
      w_tmr_nxt      = r_tmr;
      w_xfer_cnt_nxt = r_xfer_cnt;
      case (r_state)
         S_IDLE: begin
            if (io_hs.s_valid && w_s_ready) begin
               w_dout_nxt  = io_hs.s_data;
               w_state_nxt = S_LOAD;
            end
         end
         // One cycle of settled d_out before request is raised.
         S_LOAD: begin
            w_req_nxt   = 1'b1;
            w_tmr_nxt   = '0;
            w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (w_ack_sync) begin
               w_req_nxt   = 1'b0;
               w_acked_nxt = 1'b1;
               w_state_nxt = S_RELEASE;
            end else if (TO_EN && (r_tmr == TO_LAST)) begin
               w_req_nxt   = 1'b0;
               w_terr_nxt  = 1'b1;
               w_acked_nxt = 1'b0;
               w_state_nxt = S_RELEASE;
            end else begin
               w_tmr_nxt = r_tmr + TW'(1);
            end
         end
         S_RELEASE: begin
            if (!w_ack_sync) begin
               w_state_nxt = S_IDLE;
               if (r_acked) begin
                  w_done_nxt     = 1'b1;
                  w_xfer_cnt_nxt = r_xfer_cnt + COUNT_WIDTH'(1);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign io_hs.s_ready     = w_s_ready;
   assign io_hs.request     = r_req;
   assign io_hs.d_out       = r_dout;
   assign io_hs.done        = r_done;
   assign io_hs.timeout_err = r_terr;
   assign io_hs.xfer_count  = r_xfer_cnt;

endmodule

// File: tb/tb_source_handshake_ctrl.sv
// Randomized bench: a destination responder answers requests with random ack delays (or stays silent to force timeouts).
// Expectations are queued at accept time and checked by an independent monitor on the falling clock edge.
module tb_source_handshake_ctrl;

   typedef struct packed {
      logic [7:0] data;
      logic       resp;
      logic [7:0] dly;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   source_handshake_ctrl_if #(.DATA_WIDTH(8), .COUNT_WIDTH(2)) hs ();

   source_handshake_ctrl #(
      .DATA_WIDTH    (8),
      .SYNC_STAGES   (2),
      .TIMEOUT_CYCLES(16),
      .COUNT_WIDTH   (2)
   ) u_dut (
      .i_clk_s(clk),
      .i_rst  (rst),
      .io_hs  (hs)
   );

   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];
   exp_t resp_q[$];

   logic force_en = 1'b1;
   logic force_val = 1'b1;
   logic resp_ack = 1'b0;
   assign hs.ack = force_en ? force_val : resp_ack;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model state, owned by the monitor.
   int   model_cnt = 0;
   logic model_terr = 1'b0;
   int   exp_done = 0;
   int   done_total = 0;
   logic m_prev_req = 1'b0;
   logic m_prev_done = 1'b0;
   int   hi = 0;
   exp_t cur = '0;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         model_cnt = 0; model_terr = 1'b0; exp_done = 0; done_total = 0;
         m_prev_req = 1'b0; m_prev_done = 1'b0; hi = 0;
      end else begin
         if (hs.request && !m_prev_req) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL spurious_request got=1 expected=0 at %0t", $time);
               cur = '0;
            end else begin
               cur = exp_q.pop_front();
               chk("d_out_at_request", hs.d_out, cur.data);
            end
            hi = 1;
         end else if (hs.request) begin
            hi++;
            chk("d_out_stable", hs.d_out, cur.data);
            chk("s_ready_busy", hs.s_ready, 0);
         end
         if (!hs.request && m_prev_req) begin
            chk("request_high_cycles", hi, cur.resp ? cur.dly + 3 : 16);
            if (cur.resp) exp_done++;
            else model_terr = 1'b1;
            chk("timeout_err", hs.timeout_err, model_terr);
         end
         if (hs.done) begin
            done_total++;
            model_cnt = (model_cnt + 1) % 4;
            chk("done_width", m_prev_done, 0);
            chk("done_expected", done_total <= exp_done, 1);
            chk("xfer_count", hs.xfer_count, model_cnt);
         end
         m_prev_req = hs.request;
         m_prev_done = hs.done;
      end
   end

   // Destination-side responder.
   int   r_st = 0;
   int   r_cnt = 0;
   logic r_do = 1'b0;
   exp_t r_e;
   always @(negedge clk) begin
      if (rst) begin
         r_st = 0; resp_ack = 1'b0; resp_q.delete();
      end else begin
         case (r_st)
            0: if (hs.request) begin
               r_e = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
               r_do = r_e.resp; r_cnt = r_e.dly;
               r_st = r_do ? 1 : 2;
            end
            1: begin
               r_cnt--;
               if (r_cnt <= 0) begin resp_ack = 1'b1; r_st = 2; end
            end
            2: if (!hs.request) begin
               if (r_do) begin r_cnt = $urandom_range(1, 6); r_st = 3; end
               else r_st = 0;
            end
            3: begin
               r_cnt--;
               if (r_cnt <= 0) begin resp_ack = 1'b0; r_st = 0; end
            end
            default: r_st = 0;
         endcase
      end
   end

   task automatic send(input logic [7:0] d, input logic resp, input int dly);
      int n = 0;
      exp_t e;
      hs.s_valid = 1'b1;
      hs.s_data = d;
      while (!hs.s_ready && n < 400) begin @(negedge clk); n++; end
      if (!hs.s_ready) begin
         total++; bad++;
         $display("FAIL accept_wait got=timeout expected=s_ready for %0h", d);
         hs.s_valid = 1'b0;
         return;
      end
      e.data = d; e.resp = resp; e.dly = 8'(dly);
      exp_q.push_back(e);
      resp_q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      hs.s_valid = 1'b0;
      while ((exp_q.size() != 0 || !hs.s_ready) && n < 600) begin @(negedge clk); n++; end
      if (n >= 600) begin
         total++; bad++;
         $display("FAIL idle_wait got=busy expected=idle at %0t", $time);
      end
      @(negedge clk);
   endtask

   initial begin
      int k;
      hs.s_valid = 1'b0;
      hs.s_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_request", hs.request, 0);
      chk("rst_d_out", hs.d_out, 0);
      chk("rst_done", hs.done, 0);
      chk("rst_timeout_err", hs.timeout_err, 0);
      chk("rst_xfer_count", hs.xfer_count, 0);
      rst = 1'b0;

      // Stale ack held high across reset release.
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("stale_s_ready", hs.s_ready, 0);
         @(negedge clk);
      end
      force_val = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (!hs.s_ready && k < 20);
      chk("stale_release_latency", k, 2);
      force_en = 1'b0;

      send(8'hA5, 1'b1, 3);
      wait_idle();
      chk("single_xfer_count", hs.xfer_count, 1);

      send(8'h01, 1'b1, 2);
      send(8'h02, 1'b1, 5);
      send(8'h03, 1'b1, 1);
      wait_idle();
      chk("b2b_xfer_count", hs.xfer_count, 0);

      send(8'h77, 1'b0, 0);
      wait_idle();
      chk("timeout_sticky", hs.timeout_err, 1);
      send(8'h78, 1'b1, 4);
      wait_idle();
      chk("after_timeout_count", hs.xfer_count, 1);

      for (int i = 0; i < 20; i++) begin
         k = $urandom_range(0, 3);
         if (k > 0) begin
            hs.s_valid = 1'b0;
            repeat (k) @(negedge clk);
         end
         send(8'($urandom), ($urandom_range(0, 4) != 0), $urandom_range(1, 8));
      end
      wait_idle();

      // Reset while the request is outstanding.
      send(8'h3C, 1'b0, 0);
      hs.s_valid = 1'b0;
      k = 0;
      while (!hs.request && k < 50) begin @(negedge clk); k++; end
      if (!hs.request) begin
         total++; bad++;
         $display("FAIL mid_xfer_request got=0 expected=1");
      end
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_request", hs.request, 0);
      chk("midrst_done", hs.done, 0);
      chk("midrst_xfer_count", hs.xfer_count, 0);
      chk("midrst_timeout_err", hs.timeout_err, 0);
      chk("midrst_d_out", hs.d_out, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(8'h5A, 1'b1, 3);
      wait_idle();
      chk("post_rst_count", hs.xfer_count, 1);

      chk("done_total", done_total, exp_done);
      chk("xfer_count_final", hs.xfer_count, model_cnt);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/source_handshake_ctrl.md
Name: source_handshake_ctrl

Overview:
Source-domain half of the four-phase request/acknowledge CDC handshake. It accepts one word from a local valid/ready producer and holds it on d_out. It raises request and waits for the destination's ack through a local synchronizer, then drops request and waits for ack to fall before taking the next word. It sits directly upstream of destination_control: request and d_out drive its request/d_in, and its ack returns here.

Parameters:
DATA_WIDTH, 8, width of s_data/d_out
SYNC_STAGES, 2, flops in the ack synchronizer chain (legal 2..4)
TIMEOUT_CYCLES, 1024, max cycles in REQ waiting for ack; 0 disables timeout
COUNT_WIDTH, 16, width of xfer_count

Ports:
clk_s  input  1  source-domain clock
rst  input  1  asynchronous, active-high reset
s_valid  input  1  producer has a word on s_data
s_data  input  DATA_WIDTH  word to transfer
s_ready  output  1  block can accept a word this cycle
ack  input  1  acknowledge from destination domain (asynchronous to clk_s)
request  output  1  registered request to destination domain
d_out  output  DATA_WIDTH  registered data to destination domain
done  output  1  one-cycle pulse: transfer fully completed (ack seen high then low)
timeout_err  output  1  sticky: a request timed out
xfer_count  output  COUNT_WIDTH  number of completed transfers, wraps

Behaviour:
- Reset (async assert, released on clk_s): state=IDLE, request=0, d_out=0, done=0, timeout_err=0, xfer_count=0, synchronizer flops=0, timeout counter=0.
- ack_sync is the output of a SYNC_STAGES-deep flop chain on ack. The FSM never reads raw ack.
- s_ready = (state==IDLE) && !ack_sync. It is combinational from registered state.
- IDLE: on s_valid && s_ready, d_out<=s_data and go to LOAD. s_valid while s_ready=0 is ignored; the word is not consumed.
- LOAD: request<=1, clear timeout counter, go to REQ. This guarantees d_out is stable for at least 1 clk_s cycle before request rises.
- REQ: if ack_sync==1, request<=0, set acked flag, go to RELEASE. Otherwise, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1, request<=0, timeout_err<=1, clear acked flag, go to RELEASE. Otherwise increment the counter.
- RELEASE: wait for ack_sync==0. Then go to IDLE; if acked, done<=1 for one cycle and xfer_count<=xfer_count+1 (modulo 2^COUNT_WIDTH).
- d_out is held constant from LOAD until the next accept in IDLE, including while request is low in RELEASE.
- Latency: accept at edge E0; d_out valid after E0; request high after E1. request falls SYNC_STAGES+1 edges after ack rises, at minimum. done pulses SYNC_STAGES+1 edges after ack falls, at minimum.
- Stale ack high while in IDLE (e.g. after reset mid-transfer): s_ready stays 0 until ack_sync returns to 0.
- Reset mid-transfer: request drops asynchronously, the in-flight word is discarded, and xfer_count is cleared.
- timeout_err clears only on rst. After a timeout the FSM continues normally.
- ack toggling while in LOAD: ignored until REQ.
- One word in flight at most; no buffering beyond d_out.

Test Plan:
- Single transfer: reset, s_data=8'hA5 with s_valid for 1 cycle; model ack rising 3 cycles after request and falling 3 cycles after request falls -> d_out=8'hA5 before request rises; request high for ack_sync delay+1; one done pulse; xfer_count=1; s_ready=0 from accept until return to IDLE.
- Back-to-back: s_valid held high with data 8'h01,8'h02,8'h03 -> exactly 3 requests, d_out sequence 01,02,03, never changing while request=1; xfer_count=3; no word lost or duplicated.
- Timeout: TIMEOUT_CYCLES=16, ack tied 0 -> request high exactly 16 cycles then low; timeout_err=1 sticky; no done; xfer_count=0; next word accepted.
- Stale ack: reset released with ack=1 -> s_ready=0 until SYNC_STAGES cycles after ack goes 0; the first accept then behaves as in the single-transfer case.
- Reset mid-transfer: assert rst while in REQ -> request and done at 0 immediately, xfer_count=0; after release and ack low, a new word 8'h5A transfers normally.
- Wrap: COUNT_WIDTH=2, 5 transfers -> xfer_count sequence 1,2,3,0,1.
